// File: rtl/reg_dump_sequencer_pkg.sv
// reg_dump_pkg: shared types and constants for the register dump sequencer.
// Holds the FSM state enum, default geometry, the bytes-per-register constant
// and the byte order used by the serializer (MSB byte first on the wire).
// Optional feature macro used by the slice: DUMP_CHECKSUM_EN.
package reg_dump_pkg;

  localparam int DATA_W_DEFAULT   = 32;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int BYTES_PER_REG    = DATA_W_DEFAULT / 8;

  // 1: most significant byte of a word is transmitted first.
  localparam bit MSB_FIRST = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_READ,
    ST_SEND,
    ST_CSUM,
    ST_DONE
  } state_e;

  function automatic int bytes_per_word(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/reg_dump_sequencer_word_serializer.sv
// word_serializer: turns a DATA_W word into a valid/ready byte stream.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   load_i, word_i  load a full word; bytes go out in MSB_FIRST order
//   load_byte_i,
//   byte_i          load a single byte (sent as a one-byte "word")
//   data_o, valid_o byte stream out; both held stable while ready_i is low
//   ready_i         downstream accepts the byte on valid_o && ready_i
//   last_o          pulse: final byte of the current load is being accepted
// DATA_W must be a multiple of 8.
module word_serializer
  import reg_dump_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic              load_byte_i,
  input  logic [7:0]        byte_i,
  output logic [7:0]        data_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic              last_o
);

  localparam int BYTES = bytes_per_word(DATA_W);
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

  logic [DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              valid_q, valid_d;
  logic              accept;

  assign accept = valid_q && ready_i;
  assign last_o = accept && (cnt_q == LAST_CNT);

  always_comb begin
    word_d  = word_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      word_d  = word_i;
      cnt_d   = '0;
      valid_d = 1'b1;
    end else if (load_byte_i) begin
      // A single byte is staged at the output position and the counter is
      // pre-set to the last slot, so it is sent exactly once.
      word_d = '0;
      if (MSB_FIRST) word_d[DATA_W-1 -: 8] = byte_i;
      else           word_d[7:0]           = byte_i;
      cnt_d   = LAST_CNT;
      valid_d = 1'b1;
    end else if (accept) begin
      if (cnt_q == LAST_CNT) begin
        // Clear the shifter so the byte output idles at zero.
        valid_d = 1'b0;
        word_d  = '0;
      end else begin
        cnt_d  = cnt_q + 1'b1;
        word_d = MSB_FIRST ? (word_q << 8) : (word_q >> 8);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = MSB_FIRST ? word_q[DATA_W-1 -: 8] : word_q[7:0];
  assign valid_o = valid_q;

endmodule

// File: rtl/reg_dump_sequencer.sv
// reg_dump_sequencer: debug controller that stalls the pipeline, walks the
// register bank 0..NUM_REGS-1 and streams every word MSB byte first to the
// UART TX FIFO.
// Ports:
//   clk, rst      clock, asynchronous active-high reset
//   i_start       dump request, sampled only while idle
//   i_halted      pipeline reports it has drained and is frozen
//   o_stall_req   stall request, held for the whole dump
//   o_rd_addr     register-bank read address (holds its value while idle)
//   i_rd_data     register-bank read data, valid READ_LAT cycles after address
//   o_tx_data,
//   o_tx_valid,
//   i_tx_ready    byte stream to the transmitter
//   o_busy        high in every state except idle
//   o_done        one-cycle pulse at the end of the dump
// Macro DUMP_CHECKSUM_EN: append one byte holding the XOR of all sent bytes.
module reg_dump_sequencer
  import reg_dump_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEFAULT,
  parameter int NUM_REGS = NUM_REGS_DEFAULT,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int READ_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_start,
  input  logic              i_halted,
  output logic              o_stall_req,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [7:0]        o_tx_data,
  output logic              o_tx_valid,
  input  logic              i_tx_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam int LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;
  localparam logic [LAT_W-1:0] LAST_LAT = LAT_W'(READ_LAT - 1);
  // One bit wider than the address so the compare stays exact when NUM_REGS
  // is not a power of two.
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_REGS - 1);

  state_e            state_q, state_d;
  logic [ADDR_W:0]   index_q, index_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              stall_q, stall_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              ser_load;
  logic              ser_load_byte;
  logic [7:0]        ser_byte;
  logic              ser_last;
  logic [7:0]        tx_data;
  logic              tx_valid;

`ifdef DUMP_CHECKSUM_EN
  logic [7:0]        csum_q, csum_d;
`endif

  word_serializer #(
    .DATA_W (DATA_W)
  ) u_ser (
    .clk         (clk),
    .rst         (rst),
    .load_i      (ser_load),
    .word_i      (i_rd_data),
    .load_byte_i (ser_load_byte),
    .byte_i      (ser_byte),
    .data_o      (tx_data),
    .valid_o     (tx_valid),
    .ready_i     (i_tx_ready),
    .last_o      (ser_last)
  );

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    lat_d         = lat_q;
    ser_load      = 1'b0;
    ser_load_byte = 1'b0;
    ser_byte      = '0;
`ifdef DUMP_CHECKSUM_EN
    csum_d        = csum_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (i_start) begin
          state_d = ST_REQ;
          index_d = '0;
`ifdef DUMP_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end

      ST_REQ: begin
        if (i_halted) begin
          state_d = ST_READ;
          lat_d   = '0;
        end
      end

      ST_READ: begin
        if (lat_q == LAST_LAT) begin
          ser_load = 1'b1;
          state_d  = ST_SEND;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end

      ST_SEND: begin
`ifdef DUMP_CHECKSUM_EN
        if (tx_valid && i_tx_ready) csum_d = csum_q ^ tx_data;
`endif
        if (ser_last) begin
          if (index_q == LAST_IDX) begin
`ifdef DUMP_CHECKSUM_EN
            // The byte accepted on this edge is folded in directly, since
            // csum_q only catches up after the edge.
            state_d       = ST_CSUM;
            ser_load_byte = 1'b1;
            ser_byte      = csum_q ^ tx_data;
`else
            state_d = ST_DONE;
`endif
          end else begin
            index_d = index_q + 1'b1;
            lat_d   = '0;
            state_d = ST_READ;
          end
        end
      end

`ifdef DUMP_CHECKSUM_EN
      ST_CSUM: begin
        if (ser_last) state_d = ST_DONE;
      end
`endif

      ST_DONE: state_d = ST_IDLE;

      default: state_d = ST_IDLE;
    endcase

    // Outputs are registered from the next state so they change together
    // with the state they describe.
    stall_d   = (state_d == ST_REQ) || (state_d == ST_READ) ||
                (state_d == ST_SEND) || (state_d == ST_CSUM);
    busy_d    = (state_d != ST_IDLE);
    done_d    = (state_d == ST_DONE);
    rd_addr_d = (state_d == ST_READ) ? index_d[ADDR_W-1:0] : rd_addr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      index_q   <= '0;
      lat_q     <= '0;
      rd_addr_q <= '0;
      stall_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      index_q   <= index_d;
      lat_q     <= lat_d;
      rd_addr_q <= rd_addr_d;
      stall_q   <= stall_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

`ifdef DUMP_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) csum_q <= '0;
    else     csum_q <= csum_d;
  end
`endif

  assign o_stall_req = stall_q;
  assign o_rd_addr   = rd_addr_q;
  assign o_tx_data   = tx_data;
  assign o_tx_valid  = tx_valid;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: doc/reg_dump_sequencer.md
# reg_dump_sequencer

Debug controller that sequences a full readout of the MIPS register bank and streams it byte-wise to the debug UART transmitter. On a start request it asks the pipeline to stall and waits for the pipeline to report it has halted. It then walks register addresses 0..NUM_REGS-1 through a register-bank read port and serializes each word MSB-first over a valid/ready byte stream. It sits between the debug unit (start/done), the hazard/stall logic (stall request/halted) and the UART TX FIFO.

## Interface
- DATA_W, 32, register width in bits; must be a multiple of 8
- NUM_REGS, 32, number of registers dumped
- ADDR_W, $clog2(NUM_REGS), register address width
- READ_LAT, 1, cycles from address change to valid i_rd_data; minimum 1

- clk  in  1  clock, rising-edge
- rst  in  1  reset, asynchronous, active-high
- i_start  in  1  dump request; sampled only in IDLE
- i_halted  in  1  pipeline has drained and is frozen
- o_stall_req  out  1  request pipeline stall; reset 0
- o_rd_addr  out  ADDR_W  register-bank read address; reset 0
- i_rd_data  in  DATA_W  register-bank read data
- o_tx_data  out  8  byte to transmitter; reset 0
- o_tx_valid  out  1  byte valid; reset 0
- i_tx_ready  in  1  transmitter accepts byte
- o_busy  out  1  high in every state except IDLE; reset 0
- o_done  out  1  one-cycle pulse at dump end; reset 0

## Operation
- FSM states: IDLE, REQ, READ, SEND, (CSUM), DONE.
- IDLE: all outputs 0 except o_rd_addr, which holds its value. i_start=1 -> REQ with index=0.
- REQ: o_stall_req=1. i_halted=1 -> READ.
- READ: o_rd_addr=index. Stay READ_LAT cycles (counter). On the last cycle's edge, load i_rd_data into the serializer -> SEND.
- SEND: o_tx_valid=1 with o_tx_data = current byte, MSB byte first. Advance the byte on valid&&ready. o_tx_data and o_tx_valid must stay stable while ready=0.
  - After byte DATA_W/8-1: if index=NUM_REGS-1, go to CSUM (if compiled in) else DONE. Otherwise index+1 -> READ.
- DONE: o_done=1 for one cycle. o_stall_req drops in the same cycle. -> IDLE.
- o_stall_req stays 1 in REQ, READ, SEND and CSUM, independent of i_halted.
- If i_halted drops mid-dump, the dump continues and no error is raised.
- i_start while busy is ignored and not queued.
- Index counter is ADDR_W+1 bits wide so the compare with NUM_REGS-1 is exact for non-power-of-2 NUM_REGS. Index never wraps.
- Reset mid-dump: state returns to IDLE asynchronously, o_stall_req and o_tx_valid drop immediately, and a partial stream is abandoned.

## Timing
- All outputs are registered.
- i_start high at edge 0 -> o_stall_req=1 after edge 0.
- With i_halted=1 and READ_LAT=1: first o_tx_valid after edge 2.
- Per register, with ready held high: READ_LAT + DATA_W/8 cycles.
- Total busy cycles, ready always high, defaults: 1 + 32×5 + 1 = 162; 163 with checksum.
- Backpressure stretches SEND only. READ is never stalled by i_tx_ready.

## Configuration
- DUMP_CHECKSUM_EN defined:
  - A running XOR of all transmitted bytes is kept, cleared on leaving IDLE.
  - CSUM state presents it as one extra byte with the same valid/ready rules, then -> DONE.
- Not defined: no CSUM state and no checksum register; SEND goes directly to DONE.

## Structure
- Package reg_dump_pkg holds:
  - state enum
  - BYTES_PER_REG = DATA_W/8
  - the MSB-first byte-order constant
- Sub-module word_serializer:
  - load strobe plus DATA_W word in
  - valid/ready byte stream out
  - "last byte accepted" pulse
- The FSM and index counter live in the top module.

## Test plan
- Bank preloaded with reg k = 0x01000000·k + k, i_halted tied 1, ready tied 1. Expect 128 bytes: first 00 00 00 00, then 01 00 00 01, ..., last 1F 00 00 1F. o_done pulses at cycle 162.
- i_halted held 0 for 10 cycles after start: o_stall_req high, o_rd_addr constant 0, o_tx_valid 0 throughout; dump proceeds once i_halted=1.
- Random i_tx_ready at 30%: byte sequence identical to the first test; o_tx_data never changes while valid=1 and ready=0.
- rst pulsed during byte 2 of reg 7: o_stall_req and o_tx_valid are 0 in the same cycle; a new start restarts from reg 0, byte 0.
- i_start pulsed during SEND: no effect; exactly one o_done and 128 bytes.
- DUMP_CHECKSUM_EN defined, same bank as the first test: 129th byte = XOR of the previous 128 (0x00); done at cycle 163.
